// File: rtl/rvv_vd_collector.sv
// rvv_vd_collector: gathers lane-width result chunks into one VLEN-bit
// register image and issues a single body-only write to the VRF.
module rvv_vd_collector #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [4:0]        vd_addr,
    input  logic [9:0]        total_bits,
    input  logic [3:0]        in_valid,
    input  logic [255:0]      in_data,
    input  logic [39:0]       in_index,
    output logic              busy,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_addr,
    output logic [VLEN-1:0]   wb_data,
    output logic [VLEN/8-1:0] wb_be,
    output logic              done,
    output logic              err
);

    localparam int CW  = 1 << LANE_WIDTH;
    localparam int NCH = VLEN / CW;
    localparam int NB  = VLEN / 8;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t          state;
    logic [4:0]      addr_q;
    logic [9:0]      total_q;
    logic [VLEN-1:0] buf_q;
    logic [NCH-1:0]  cov_q;

    logic [VLEN-1:0] buf_n;
    logic [NCH-1:0]  cov_n;
    logic [NCH-1:0]  need;
    logic [VLEN-1:0] dmask;
    logic [NB-1:0]   be;
    logic [9:0]      idx;
    logic            hit_err;
    logic            all_cov;
    logic            data_unused;

    // only the low CW bits of each lane slot carry data
    assign data_unused = ^in_data;

    // merge this cycle's chunks; later lanes override earlier ones
    always_comb begin
        buf_n   = buf_q;
        cov_n   = cov_q;
        hit_err = 1'b0;
        idx     = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i]) begin
                idx = in_index[10*i +: 10];
                if (idx[LANE_WIDTH-1:0] != '0 ||
                    int'(idx) + CW > int'(total_q)) begin
                    hit_err = 1'b1;
                end else begin
                    for (int c = 0; c < NCH; c++) begin
                        if (int'(idx >> LANE_WIDTH) == c) begin
                            if (cov_n[c])
                                hit_err = 1'b1;
                            cov_n[c] = 1'b1;
                            buf_n[c*CW +: CW] = in_data[64*i +: CW];
                        end
                    end
                end
            end
        end
    end

    // body masks derived from the latched length
    always_comb begin
        need  = '0;
        dmask = '0;
        be    = '0;
        for (int c = 0; c < NCH; c++)
            need[c] = (c < (int'(total_q) >> LANE_WIDTH));
        for (int k = 0; k < VLEN; k++)
            dmask[k] = (k < int'(total_q));
        for (int b = 0; b < NB; b++)
            be[b] = (b < (int'(total_q) >> 3));
    end

    assign all_cov = ((cov_n & need) == need);
    assign wb_addr = addr_q;
    assign wb_data = buf_q & dmask;
    assign wb_be   = be;

    // control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wb_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            addr_q   <= '0;
            total_q  <= '0;
            buf_q    <= '0;
            cov_q    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= vd_addr;
                        total_q <= total_bits;
                        err     <= 1'b0;
                        if (total_bits != '0) begin
                            buf_q <= '0;
                            cov_q <= '0;
                            busy  <= 1'b1;
                            state <= COLLECT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    buf_q <= buf_n;
                    cov_q <= cov_n;
                    if (hit_err)
                        err <= 1'b1;
                    if (all_cov) begin
                        wb_valid <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (|in_valid)
                        err <= 1'b1;
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_vd_collector.sv
// tb_rvv_vd_collector: directed scoreboard bench for the
// vector write-back collector (VLEN=128, CW=8).
module tb_rvv_vd_collector;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [4:0]   vd_addr;
    logic [9:0]   total_bits;
    logic [3:0]   in_valid;
    logic [255:0] in_data;
    logic [39:0]  in_index;
    logic         busy;
    logic         wb_valid;
    logic         wb_ready;
    logic [4:0]   wb_addr;
    logic [127:0] wb_data;
    logic [15:0]  wb_be;
    logic         done;
    logic         err;

    typedef struct packed {
        logic [4:0]   a;
        logic [127:0] d;
        logic [15:0]  be;
    } wb_t;

    wb_t sbq[$];
    wb_t e;
    int  checks = 0;
    int  errors = 0;

    rvv_vd_collector #(.VLEN(128), .LANE_WIDTH(3)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .vd_addr(vd_addr), .total_bits(total_bits),
        .in_valid(in_valid), .in_data(in_data), .in_index(in_index),
        .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        in_valid = '0;
        in_data  = '0;
        in_index = '0;
    endtask

    task automatic lane(input int l, input int idx, input logic [7:0] d);
        in_valid[l]         = 1'b1;
        in_index[10*l +: 10] = 10'(idx);
        in_data[64*l +: 64]  = 64'(d);
    endtask

    task automatic go(input logic [4:0] a, input int tot);
        start      = 1'b1;
        vd_addr    = a;
        total_bits = 10'(tot);
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [127:0] d,
                            input int tot);
        wb_t x;
        x.a  = a;
        x.d  = d;
        x.be = '0;
        for (int b = 0; b < 16; b++)
            x.be[b] = (b < tot / 8);
        sbq.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        chk({tag, "_valid"}, 128'(wb_valid), 128'(1));
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, "_addr"}, 128'(wb_addr), 128'(e.a));
            chk({tag, "_data"}, wb_data, e.d);
            chk({tag, "_be"}, 128'(wb_be), 128'(e.be));
        end
    endtask

    task automatic finish_hs(input string tag);
        tick();
        chk({tag, "_done"}, 128'(done), 128'(1));
        chk({tag, "_vlow"}, 128'(wb_valid), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        tick();
        chk({tag, "_done1"}, 128'(done), 128'(0));
    endtask

    initial begin
        logic [127:0] d;
        resetn   = 1'b0;
        start    = 1'b0;
        vd_addr  = '0;
        total_bits = '0;
        wb_ready = 1'b1;
        clr();
        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_wbv", 128'(wb_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_addr", 128'(wb_addr), 128'(0));
        chk("rst_data", wb_data, 128'(0));
        chk("rst_be", 128'(wb_be), 128'(0));
        resetn = 1'b1;
        tick();

        // single-cycle full delivery
        go(5'd3, 32);
        chk("t1_busy", 128'(busy), 128'(1));
        lane(0, 0, 8'h11);
        lane(1, 8, 8'h22);
        lane(2, 16, 8'h33);
        lane(3, 24, 8'h44);
        push_exp(5'd3, 128'h44332211, 32);
        tick();
        clr();
        pop_check("t1");
        finish_hs("t1");
        chk("t1_err", 128'(err), 128'(0));

        // out-of-order delivery
        d = '0;
        for (int k = 0; k < 8; k++)
            d[8*k +: 8] = 8'(8'hA0 + k);
        go(5'd7, 64);
        lane(0, 56, 8'hA7);
        tick();
        clr();
        chk("t2_early0", 128'(wb_valid), 128'(0));
        tick();
        lane(0, 0, 8'hA0);
        lane(1, 8, 8'hA1);
        lane(2, 16, 8'hA2);
        tick();
        clr();
        chk("t2_early1", 128'(wb_valid), 128'(0));
        lane(3, 24, 8'hA3);
        lane(1, 32, 8'hA4);
        tick();
        clr();
        chk("t2_early2", 128'(wb_valid), 128'(0));
        lane(2, 40, 8'hA5);
        lane(0, 48, 8'hA6);
        push_exp(5'd7, d, 64);
        tick();
        clr();
        pop_check("t2");
        finish_hs("t2");
        chk("t2_err", 128'(err), 128'(0));

        // backpressure with full-width body
        d = '0;
        for (int k = 0; k < 16; k++)
            d[8*k +: 8] = 8'(k * 3 + 1);
        wb_ready = 1'b0;
        go(5'd12, 128);
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 4; l++)
                lane(l, (4*c + l) * 8, 8'((4*c + l) * 3 + 1));
            tick();
            clr();
        end
        push_exp(5'd12, d, 128);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_v", 128'(wb_valid), 128'(1));
            chk("t3_hold_d", wb_data, sbq[0].d);
            chk("t3_hold_a", 128'(wb_addr), 128'(sbq[0].a));
            chk("t3_hold_done", 128'(done), 128'(0));
            if (i == 1)
                lane(0, 0, 8'hFF);
            tick();
            clr();
        end
        chk("t3_werr", 128'(err), 128'(1));
        pop_check("t3");
        wb_ready = 1'b1;
        finish_hs("t3");

        // index past body
        go(5'd1, 32);
        chk("t4a_errclr", 128'(err), 128'(0));
        lane(0, 32, 8'h55);
        tick();
        clr();
        chk("t4a_err", 128'(err), 128'(1));
        chk("t4a_nowb", 128'(wb_valid), 128'(0));
        lane(0, 0, 8'h10);
        lane(1, 8, 8'h20);
        lane(2, 16, 8'h30);
        lane(3, 24, 8'h40);
        push_exp(5'd1, 128'h40302010, 32);
        tick();
        clr();
        pop_check("t4a");
        finish_hs("t4a");

        // misaligned index
        go(5'd2, 32);
        chk("t4b_errclr", 128'(err), 128'(0));
        lane(1, 4, 8'h66);
        tick();
        clr();
        chk("t4b_err", 128'(err), 128'(1));
        chk("t4b_nowb", 128'(wb_valid), 128'(0));
        lane(0, 0, 8'h01);
        lane(1, 8, 8'h02);
        lane(2, 16, 8'h03);
        lane(3, 24, 8'h04);
        push_exp(5'd2, 128'h04030201, 32);
        tick();
        clr();
        pop_check("t4b");
        finish_hs("t4b");

        // duplicate index in one cycle
        go(5'd4, 32);
        chk("t4c_errclr", 128'(err), 128'(0));
        lane(0, 8, 8'hAA);
        lane(1, 0, 8'h01);
        lane(2, 8, 8'hBB);
        lane(3, 16, 8'h03);
        tick();
        clr();
        chk("t4c_err", 128'(err), 128'(1));
        chk("t4c_nowb", 128'(wb_valid), 128'(0));
        lane(0, 24, 8'h04);
        push_exp(5'd4, 128'h0403BB01, 32);
        tick();
        clr();
        pop_check("t4c");
        finish_hs("t4c");

        // reset mid-collection
        go(5'd9, 32);
        lane(0, 0, 8'hDE);
        lane(1, 8, 8'hAD);
        tick();
        clr();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_be", 128'(wb_be), 128'(0));
        chk("t5_data", wb_data, 128'(0));
        chk("t5_wbv", 128'(wb_valid), 128'(0));
        go(5'd9, 32);
        lane(2, 16, 8'h0A);
        lane(3, 24, 8'h0B);
        tick();
        clr();
        chk("t5_partial", 128'(wb_valid), 128'(0));
        lane(0, 0, 8'h0C);
        lane(1, 8, 8'h0D);
        push_exp(5'd9, 128'h0B0A0D0C, 32);
        tick();
        clr();
        pop_check("t5");
        finish_hs("t5");
        chk("t5_err", 128'(err), 128'(0));

        // zero-length collection
        go(5'd4, 0);
        chk("t6_done", 128'(done), 128'(1));
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_wbv", 128'(wb_valid), 128'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_done0", 128'(done), 128'(0));
            chk("t6_wbv0", 128'(wb_valid), 128'(0));
            chk("t6_busy0", 128'(busy), 128'(0));
        end

        chk("sb_empty", 128'(sbq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
